// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding,
// counter width, control/hazard bundles and the register-match helper.
package hazard_ctrl_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_e;

   typedef struct packed {
      logic load_use;
      logic br_alu;
      logic br_load_mem;
      logic long_stall;
   } hazard_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
   localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};
   localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b0};

   // Register 0 is hardwired to zero and can never carry a dependency.
   function automatic logic reg_match(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic             uses_rt);
      return (r != '0) && ((r == rs) || (uses_rt && (r == rt)));
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// 16-bit event counter with enable and synchronous clear; holds at all-ones.
module sat_counter16
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: load-use and branch-operand stalls, branch/jump
// flushes, a two-cycle HOLD for branches waiting on a load, and event counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             idUsesRt,
   input  logic             idBranch,
   input  logic             idJump,
   input  logic             pcSrc,
   input  logic             exMemRead,
   input  logic             exRegWrite,
   input  logic [REG_W-1:0] exDest,
   input  logic             memMemRead,
   input  logic [REG_W-1:0] memDest,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexBubble,
   output logic [CNT_W-1:0] stallCount,
   output logic [CNT_W-1:0] flushCount,
   output logic             busy
);

   state_e  state_q;
   state_e  state_d;
   hazard_t haz;
   logic    hazard;
   logic    ex_match;
   logic    mem_match;
   ctrl_t   ctrl;

   always_comb begin
      ex_match        = reg_match(exDest, idRs, idRt, idUsesRt);
      mem_match       = reg_match(memDest, idRs, idRt, idUsesRt);
      haz.load_use    = exMemRead & ex_match;
      haz.br_alu      = idBranch & exRegWrite & ~exMemRead & ex_match;
      haz.br_load_mem = idBranch & memMemRead & mem_match;
      haz.long_stall  = idBranch & exMemRead & ex_match;
      hazard          = haz.load_use | haz.br_alu | haz.br_load_mem;
   end

   // Stall outranks flush: branch operands are stale while stalling.
   always_comb begin
      state_d = state_q;
      ctrl    = CTRL_RUN;
      case (state_q)
         RUN: begin
            if (hazard) begin
               ctrl = CTRL_STALL;
               if (haz.long_stall) begin
                  state_d = HOLD;
               end
            end else if (pcSrc | idJump) begin
               ctrl = CTRL_FLUSH;
            end
         end
         HOLD: begin
            ctrl    = CTRL_STALL;
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      if (rst) begin
         ctrl = CTRL_RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign pcWrite    = ctrl.pc_write;
   assign ifidWrite  = ctrl.ifid_write;
   assign ifidFlush  = ctrl.ifid_flush;
   assign idexBubble = ctrl.idex_bubble;
   assign busy       = (state_q == HOLD);

   sat_counter16 u_stall_cnt (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ctrl.idex_bubble),
      .clr_i   (1'b0),
      .count_o (stallCount)
   );

   sat_counter16 u_flush_cnt (
      .clk     (clk),
      .rst     (rst),
      .en_i    (ctrl.ifid_flush),
      .clr_i   (1'b0),
      .count_o (flushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized checks of hazard_ctrl against a cycle-level
// behavioural model of stall/flush rules and saturating counters.
module tb_hazard_ctrl;

   logic        clk;
   logic        rst;
   logic [4:0]  idRs;
   logic [4:0]  idRt;
   logic        idUsesRt;
   logic        idBranch;
   logic        idJump;
   logic        pcSrc;
   logic        exMemRead;
   logic        exRegWrite;
   logic [4:0]  exDest;
   logic        memMemRead;
   logic [4:0]  memDest;
   logic        pcWrite;
   logic        ifidWrite;
   logic        ifidFlush;
   logic        idexBubble;
   logic [15:0] stallCount;
   logic [15:0] flushCount;
   logic        busy;

   int total;
   int passed;

   // Model state: a pending forced-stall cycle and the two event tallies.
   bit m_hold;
   int m_stall;
   int m_flush;

   hazard_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .idRs       (idRs),
      .idRt       (idRt),
      .idUsesRt   (idUsesRt),
      .idBranch   (idBranch),
      .idJump     (idJump),
      .pcSrc      (pcSrc),
      .exMemRead  (exMemRead),
      .exRegWrite (exRegWrite),
      .exDest     (exDest),
      .memMemRead (memMemRead),
      .memDest    (memDest),
      .pcWrite    (pcWrite),
      .ifidWrite  (ifidWrite),
      .ifidFlush  (ifidFlush),
      .idexBubble (idexBubble),
      .stallCount (stallCount),
      .flushCount (flushCount),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic bit dep(input logic [4:0] r);
      return (r != 5'd0) && ((r == idRs) || (idUsesRt && (r == idRt)));
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit uses_rt,
                        input bit br, input bit jmp, input bit src,
                        input bit ex_mr, input bit ex_rw, input logic [4:0] ex_d,
                        input bit mem_mr, input logic [4:0] mem_d);
      idRs = rs; idRt = rt; idUsesRt = uses_rt; idBranch = br; idJump = jmp; pcSrc = src;
      exMemRead = ex_mr; exRegWrite = ex_rw; exDest = ex_d;
      memMemRead = mem_mr; memDest = mem_d;
   endtask

   task automatic neutral();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
   endtask

   // One clock: evaluate the rules at the negedge, compare, then advance the model.
   task automatic cycle(input bit do_chk);
      bit ld_dep, stall, flush, long_dep;
      @(negedge clk);
      if (rst) begin
         m_hold = 1'b0; m_stall = 0; m_flush = 0;
      end
      ld_dep   = exMemRead && dep(exDest);
      long_dep = idBranch && ld_dep;
      if (rst) begin
         stall = 1'b0;
         flush = 1'b0;
      end else begin
         stall = m_hold || ld_dep
                 || (idBranch && exRegWrite && !exMemRead && dep(exDest))
                 || (idBranch && memMemRead && dep(memDest));
         flush = !stall && (pcSrc || idJump);
      end
      if (do_chk) begin
         chk("pcWrite",    32'(pcWrite),    32'(!stall));
         chk("ifidWrite",  32'(ifidWrite),  32'(!stall));
         chk("ifidFlush",  32'(ifidFlush),  32'(flush));
         chk("idexBubble", 32'(idexBubble), 32'(stall));
         chk("busy",       32'(busy),       32'(m_hold));
         chk("stallCount", 32'(stallCount), 32'(m_stall));
         chk("flushCount", 32'(flushCount), 32'(m_flush));
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         if (stall && m_stall < 65535) m_stall++;
         if (flush && m_flush < 65535) m_flush++;
         m_hold = !m_hold && long_dep;
      end
   endtask

   initial begin
      total = 0; passed = 0;
      m_hold = 1'b0; m_stall = 0; m_flush = 0;
      rst = 1'b1;
      neutral();
      cycle(1'b1);
      cycle(1'b1);
      rst = 1'b0;
      cycle(1'b1);

      // lw $2 in EX, add reads $2: single stall
      drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
      cycle(1'b1);
      neutral();
      cycle(1'b1);
      chk("s1_stalls", 32'(stallCount), 32'd1);

      // beq on $3 behind lw $3: RUN, HOLD, RUN
      drive(5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
      cycle(1'b1);
      chk("s2_busy_hold", 32'(busy), 32'd1);
      cycle(1'b1);
      drive(5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3);
      cycle(1'b1);
      chk("s2_stalls", 32'(stallCount), 32'd3);
      chk("s2_busy_off", 32'(busy), 32'd0);

      // beq on rt=$4 behind add $4: one stall, then taken branch flushes
      drive(5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0);
      cycle(1'b1);
      drive(5'd1, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4);
      cycle(1'b1);
      chk("s3_stalls", 32'(stallCount), 32'd4);
      chk("s3_flushes", 32'(flushCount), 32'd1);

      // taken branch coincident with load-use: stall wins
      drive(5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0);
      cycle(1'b1);
      chk("s4_flushes", 32'(flushCount), 32'd1);
      chk("s4_stalls", 32'(stallCount), 32'd5);

      // $0 never hazardous
      drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0);
      cycle(1'b1);
      chk("s5_no_stall", 32'(stallCount), 32'd5);

      // randomized traffic with small register space to provoke matches
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom),
               1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)));
         cycle(1'b1);
      end
      rst = 1'b0;
      neutral();
      cycle(1'b1);

      // long run of load-use stalls drives stallCount into saturation
      drive(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0);
      for (int i = 0; i < 65600; i++) cycle(1'b0);
      cycle(1'b1);
      chk("sat_stalls", 32'(stallCount), 32'hFFFF);
      cycle(1'b1);
      chk("sat_hold", 32'(stallCount), 32'hFFFF);

      // reset asserted while in HOLD
      drive(5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
      cycle(1'b1);
      chk("rst_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_pc", 32'(pcWrite), 32'd1);
      chk("rst_async_bubble", 32'(idexBubble), 32'd0);
      chk("rst_async_stalls", 32'(stallCount), 32'd0);
      chk("rst_async_flushes", 32'(flushCount), 32'd0);
      cycle(1'b1);
      rst = 1'b0;
      neutral();
      cycle(1'b1);
      cycle(1'b1);
      chk("rst_no_residual", 32'(stallCount), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
